comm_mux: RTL and testbench

COMM_MUX -- requirements
Module: comm_mux

---
 rtl/comm_mux_pkg.sv | 21 ++
 rtl/comm_mux_arb.sv | 45 ++++
 rtl/comm_mux.sv | 251 +++++++++++++++++++++++++
 tb/tb_comm_mux.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_mux_pkg.sv
// Shared constants and state types for the host/console byte multiplexer.
package comm_mux_pkg;

    localparam logic [1:0] OpNop     = 2'b00;
    localparam logic [1:0] OpWrite   = 2'b01;
    localparam logic [1:0] OpSetMask = 2'b10;
    localparam logic [1:0] OpStatus  = 2'b11;

    localparam int unsigned HdrOpMsb  = 7;
    localparam int unsigned HdrOpLsb  = 6;
    localparam int unsigned HdrArgMsb = 5;
    localparam int unsigned HdrArgLsb = 0;

    typedef enum logic [1:0] {PsIdle, PsWrData, PsMaskData} parse_state_e;
    typedef enum logic [1:0] {TxIdle, TxHdr, TxData, TxStat} tx_state_e;

    function automatic logic [7:0] chan_header(input logic [2:0] ch);
        return {OpWrite, 3'b000, ch};
    endfunction

endpackage

// File: rtl/comm_mux_arb.sv
// Round-robin arbiter: searches from the channel after the last grant.
module comm_mux_arb #(
    parameter int unsigned N_CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [2:0]      grant,
    output logic            any_valid
);

    logic [2:0] ptr_q, ptr_d;

    always_comb begin
        grant     = ptr_q;
        any_valid = 1'b0;
        // First pass covers ptr..N_CH-1, second pass wraps to 0..ptr-1.
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (!any_valid && req[ch] && (3'(ch) >= ptr_q)) begin
                any_valid = 1'b1;
                grant     = 3'(ch);
            end
        end
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (!any_valid && req[ch] && (3'(ch) < ptr_q)) begin
                any_valid = 1'b1;
                grant     = 3'(ch);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && any_valid) begin
            ptr_d = (grant == 3'(N_CH - 1)) ? 3'd0 : grant + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 3'd0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/comm_mux.sv
// Host <-> console byte multiplexer: host command parser, per-channel holding bytes, host TX FSM.
// Define COMM_MUX_OVERRUN_EN to add sticky per-channel overrun flags and a second STATUS byte.
module comm_mux
    import comm_mux_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CMD_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_rx_valid,
    input  logic [7:0]        host_rx_data,
    output logic [7:0]        host_tx_data,
    output logic              host_tx_start,
    input  logic              host_tx_done,
    input  logic [N_CH-1:0]   ch_rx_valid,
    input  logic [8*N_CH-1:0] ch_rx_data,
    output logic [7:0]        ch_tx_data,
    output logic [N_CH-1:0]   ch_tx_start,
    input  logic [N_CH-1:0]   ch_tx_done
);

    localparam int unsigned TW = $clog2(CMD_TIMEOUT + 1);

    parse_state_e           ps_q, ps_d;
    logic [5:0]             arg_q, arg_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [N_CH-1:0]        read_mask_q, read_mask_d;
    logic [N_CH-1:0]        busy_q, busy_d;
    logic [N_CH-1:0]        ch_tx_start_q, ch_tx_start_d;
    logic [7:0]             ch_tx_data_q, ch_tx_data_d;
    logic                   status_pend_q, status_pend_d;
    logic                   status_set, wr_ok;
    logic [7:0]             busy_ext;

    tx_state_e              tx_q, tx_d;
    logic [7:0]             host_tx_data_q, host_tx_data_d;
    logic                   host_tx_start_q, host_tx_start_d;
    logic [7:0]             pair_data_q, pair_data_d;
    logic [N_CH-1:0]        hold_full_q, hold_full_d;
    logic [N_CH-1:0][7:0]   hold_data_q, hold_data_d;
    logic [N_CH-1:0]        free;
    logic                   advance, launch_next, any_valid;
    logic [2:0]             grant;
    logic [7:0]             grant_data;

`ifdef COMM_MUX_OVERRUN_EN
    logic [N_CH-1:0]        ovr_q, ovr_d, ovr_set;
    logic                   stat2_q, stat2_d, ovr_clear;
`endif

    comm_mux_arb #(.N_CH(N_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (hold_full_q),
        .advance   (advance),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign busy_ext = 8'(busy_q);
    assign wr_ok    = (arg_q < 6'(N_CH)) && !busy_ext[arg_q[2:0]];

    // Host command parser.
    always_comb begin
        ps_d          = ps_q;
        arg_d         = arg_q;
        timer_d       = timer_q;
        read_mask_d   = read_mask_q;
        ch_tx_start_d = '0;
        ch_tx_data_d  = ch_tx_data_q;
        status_set    = 1'b0;
        busy_d        = busy_q & ~ch_tx_done;
        unique case (ps_q)
            PsIdle: begin
                if (host_rx_valid) begin
                    timer_d = '0;
                    arg_d   = host_rx_data[HdrArgMsb:HdrArgLsb];
                    unique case (host_rx_data[HdrOpMsb:HdrOpLsb])
                        OpWrite:   ps_d = PsWrData;
                        OpSetMask: ps_d = PsMaskData;
                        OpStatus:  status_set = 1'b1;
                        default:   ;
                    endcase
                end
            end
            PsWrData, PsMaskData: begin
                // A byte in the expiry cycle still counts as the payload.
                if (host_rx_valid) begin
                    ps_d = PsIdle;
                    if (ps_q == PsMaskData) begin
                        read_mask_d = host_rx_data[N_CH-1:0];
                    end else if (wr_ok) begin
                        ch_tx_data_d = host_rx_data;
                        for (int unsigned ch = 0; ch < N_CH; ch++) begin
                            if (3'(ch) == arg_q[2:0]) begin
                                ch_tx_start_d[ch] = 1'b1;
                                busy_d[ch]        = 1'b1;
                            end
                        end
                    end
                end else if (timer_q == TW'(CMD_TIMEOUT - 1)) begin
                    ps_d = PsIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ps_d = PsIdle;
        endcase
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (3'(ch) == grant) grant_data = hold_data_q[ch];
        end
    end

    // Host TX FSM: one byte in flight at a time, pairs never interleaved.
    always_comb begin
        tx_d            = tx_q;
        host_tx_start_d = 1'b0;
        host_tx_data_d  = host_tx_data_q;
        pair_data_d     = pair_data_q;
        status_pend_d   = status_pend_q;
        free            = '0;
        advance         = 1'b0;
        launch_next     = 1'b0;
`ifdef COMM_MUX_OVERRUN_EN
        stat2_d         = stat2_q;
        ovr_clear       = 1'b0;
`endif
        unique case (tx_q)
            TxIdle: launch_next = 1'b1;
            TxHdr: begin
                if (host_tx_done) begin
                    tx_d            = TxData;
                    host_tx_start_d = 1'b1;
                    host_tx_data_d  = pair_data_q;
                end
            end
            TxData: launch_next = host_tx_done;
            TxStat: begin
`ifdef COMM_MUX_OVERRUN_EN
                if (host_tx_done && stat2_q) begin
                    host_tx_start_d = 1'b1;
                    host_tx_data_d  = 8'(ovr_q);
                    stat2_d         = 1'b0;
                    ovr_clear       = 1'b1;
                end else begin
                    launch_next = host_tx_done;
                end
`else
                launch_next = host_tx_done;
`endif
            end
            default: tx_d = TxIdle;
        endcase
        if (launch_next) begin
            tx_d = TxIdle;
            if (status_pend_q) begin
                tx_d            = TxStat;
                host_tx_start_d = 1'b1;
                host_tx_data_d  = 8'(read_mask_q);
                status_pend_d   = 1'b0;
`ifdef COMM_MUX_OVERRUN_EN
                stat2_d         = 1'b1;
`endif
            end else if (any_valid) begin
                tx_d            = TxHdr;
                host_tx_start_d = 1'b1;
                host_tx_data_d  = chan_header(grant);
                pair_data_d     = grant_data;
                advance         = 1'b1;
                for (int unsigned ch = 0; ch < N_CH; ch++) begin
                    if (3'(ch) == grant) free[ch] = 1'b1;
                end
            end
        end
        if (status_set) status_pend_d = 1'b1;
    end

    // Holding bytes: a fresh byte wins over the free issued by a header start.
    always_comb begin
        hold_full_d = hold_full_q & ~free;
        hold_data_d = hold_data_q;
`ifdef COMM_MUX_OVERRUN_EN
        ovr_set     = '0;
`endif
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (ch_rx_valid[ch] && read_mask_q[ch]) begin
                hold_full_d[ch] = 1'b1;
                hold_data_d[ch] = ch_rx_data[8*ch +: 8];
`ifdef COMM_MUX_OVERRUN_EN
                if (hold_full_q[ch] && !free[ch]) ovr_set[ch] = 1'b1;
`endif
            end
        end
`ifdef COMM_MUX_OVERRUN_EN
        ovr_d = (ovr_clear ? '0 : ovr_q) | ovr_set;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q            <= PsIdle;
            arg_q           <= '0;
            timer_q         <= '0;
            read_mask_q     <= '0;
            busy_q          <= '0;
            ch_tx_start_q   <= '0;
            ch_tx_data_q    <= '0;
            status_pend_q   <= 1'b0;
            tx_q            <= TxIdle;
            host_tx_data_q  <= '0;
            host_tx_start_q <= 1'b0;
            pair_data_q     <= '0;
            hold_full_q     <= '0;
            hold_data_q     <= '0;
`ifdef COMM_MUX_OVERRUN_EN
            ovr_q           <= '0;
            stat2_q         <= 1'b0;
`endif
        end else begin
            ps_q            <= ps_d;
            arg_q           <= arg_d;
            timer_q         <= timer_d;
            read_mask_q     <= read_mask_d;
            busy_q          <= busy_d;
            ch_tx_start_q   <= ch_tx_start_d;
            ch_tx_data_q    <= ch_tx_data_d;
            status_pend_q   <= status_pend_d;
            tx_q            <= tx_d;
            host_tx_data_q  <= host_tx_data_d;
            host_tx_start_q <= host_tx_start_d;
            pair_data_q     <= pair_data_d;
            hold_full_q     <= hold_full_d;
            hold_data_q     <= hold_data_d;
`ifdef COMM_MUX_OVERRUN_EN
            ovr_q           <= ovr_d;
            stat2_q         <= stat2_d;
`endif
        end
    end

    assign host_tx_data  = host_tx_data_q;
    assign host_tx_start = host_tx_start_q;
    assign ch_tx_data    = ch_tx_data_q;
    assign ch_tx_start   = ch_tx_start_q;

endmodule

// File: tb/tb_comm_mux.sv
// Directed bench for comm_mux: host commands, channel traffic, STATUS, timeout and reset.
module tb_comm_mux;

    localparam int unsigned NCh     = 4;
    localparam int unsigned Timeout = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             host_rx_valid;
    logic [7:0]       host_rx_data;
    logic [7:0]       host_tx_data;
    logic             host_tx_start;
    logic             host_tx_done;
    logic [NCh-1:0]   ch_rx_valid;
    logic [8*NCh-1:0] ch_rx_data;
    logic [7:0]       ch_tx_data;
    logic [NCh-1:0]   ch_tx_start;
    logic [NCh-1:0]   ch_tx_done;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] tx_log[$];
    int         ch_cnt[NCh];
    int         ch_total = 0;
    logic       stall = 1'b0;
    logic       pend = 1'b0;
    int         proto_err = 0;

    always #5 clk = ~clk;

    comm_mux #(.N_CH(NCh), .CMD_TIMEOUT(Timeout)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_rx_valid (host_rx_valid),
        .host_rx_data  (host_rx_data),
        .host_tx_data  (host_tx_data),
        .host_tx_start (host_tx_start),
        .host_tx_done  (host_tx_done),
        .ch_rx_valid   (ch_rx_valid),
        .ch_rx_data    (ch_rx_data),
        .ch_tx_data    (ch_tx_data),
        .ch_tx_start   (ch_tx_start),
        .ch_tx_done    (ch_tx_done)
    );

    // Host transmitter model: logs each started byte, answers done one cycle later unless stalled.
    initial begin
        host_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            host_tx_done = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else if (host_tx_start) begin
                if (pend) proto_err++;
                tx_log.push_back(host_tx_data);
                pend = 1'b1;
            end else if (pend && !stall) begin
                host_tx_done = 1'b1;
                pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NCh; i++) begin
            if (ch_tx_start[i] === 1'b1) begin
                ch_cnt[i]++;
                ch_total++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < tx_log.size()) return 32'(tx_log[i]);
        return 32'hDEAD;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic host_send(input logic [7:0] b);
        @(negedge clk);
        host_rx_valid = 1'b1;
        host_rx_data  = b;
        @(negedge clk);
        host_rx_valid = 1'b0;
    endtask

    task automatic ch_send(input logic [NCh-1:0] v, input logic [8*NCh-1:0] d);
        @(negedge clk);
        ch_rx_valid = v;
        ch_rx_data  = d;
        @(negedge clk);
        ch_rx_valid = '0;
    endtask

    task automatic ch_done(input int ch);
        @(negedge clk);
        ch_tx_done[ch] = 1'b1;
        @(negedge clk);
        ch_tx_done[ch] = 1'b0;
    endtask

    task automatic wait_log(input int n, input string tag);
        int cyc = 0;
        while (tx_log.size() < n && cyc < 300) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check(tag, 32'(tx_log.size()), 32'(n));
    endtask

    initial begin
        for (int i = 0; i < NCh; i++) ch_cnt[i] = 0;
        rst           = 1'b1;
        host_rx_valid = 1'b0;
        host_rx_data  = '0;
        ch_rx_valid   = '0;
        ch_rx_data    = '0;
        ch_tx_done    = '0;
        tick(2);
        check("rst_host_tx_start", 32'(host_tx_start), 32'h0);
        check("rst_host_tx_data", 32'(host_tx_data), 32'h0);
        check("rst_ch_tx_start", 32'(ch_tx_start), 32'h0);
        check("rst_ch_tx_data", 32'(ch_tx_data), 32'h0);
        rst = 1'b0;
        tick(2);

        // WRITE to channel 1, then a second WRITE while still busy.
        host_send(8'h41);
        host_send(8'h55);
        #1;
        check("wr_start_vec", 32'(ch_tx_start), 32'h2);
        check("wr_data", 32'(ch_tx_data), 32'h55);
        tick(3);
        check("wr_ch1_once", 32'(ch_cnt[1]), 32'd1);
        check("wr_total_once", 32'(ch_total), 32'd1);
        host_send(8'h41);
        host_send(8'h66);
        #1;
        check("busy_drop_start", 32'(ch_tx_start), 32'h0);
        tick(3);
        check("busy_drop_cnt", 32'(ch_total), 32'd1);
        check("busy_drop_data", 32'(ch_tx_data), 32'h55);
        ch_done(1);
        host_send(8'h41);
        host_send(8'h77);
        tick(3);
        check("after_done_cnt", 32'(ch_cnt[1]), 32'd2);
        check("after_done_data", 32'(ch_tx_data), 32'h77);
        ch_done(1);
        host_send(8'h45);   // channel 5 does not exist
        host_send(8'h99);
        tick(3);
        check("bad_arg_drop", 32'(ch_total), 32'd2);

        // SET_MASK then STATUS.
        host_send(8'h80);
        host_send(8'h05);
        host_send(8'hC0);
`ifdef COMM_MUX_OVERRUN_EN
        wait_log(2, "stat_count");
        check("stat_ovr_byte", log_at(1), 32'h00);
`else
        wait_log(1, "stat_count");
`endif
        check("stat_mask_byte", log_at(0), 32'h05);
        tick(6);
        check("stat_no_extra", 32'(tx_log.size()), 32'(log_at(0) == 32'h05 ? tx_log.size() : 99));
        tx_log.delete();

        // Two channels fill in the same cycle; round-robin starts at channel 0.
        host_send(8'h80);
        host_send(8'h0F);
        ch_send(4'b0101, 32'h00BB_00AA);
        wait_log(4, "pair_count");
        check("pair_hdr0", log_at(0), 32'h40);
        check("pair_data0", log_at(1), 32'hAA);
        check("pair_hdr2", log_at(2), 32'h42);
        check("pair_data2", log_at(3), 32'hBB);
        tx_log.delete();

        // Overwrite of a full holding byte while host TX is stalled; ch1 is masked off.
        host_send(8'h80);
        host_send(8'h01);
        stall = 1'b1;
        host_send(8'hC0);
        wait_log(1, "stall_stat_count");
        check("stall_stat_byte", log_at(0), 32'h01);
        ch_send(4'b0011, 32'h0000_7711);
        ch_send(4'b0001, 32'h0000_0022);
        tick(3);
        stall = 1'b0;
`ifdef COMM_MUX_OVERRUN_EN
        wait_log(4, "ovr_count");
        check("ovr_flag_byte", log_at(1), 32'h01);
        check("ovr_hdr", log_at(2), 32'h40);
        check("ovr_data", log_at(3), 32'h22);
        tick(8);
        check("ovr_no_extra", 32'(tx_log.size()), 32'd4);
        tx_log.delete();
        host_send(8'hC0);
        wait_log(2, "ovr_stat2_count");
        check("ovr_stat2_mask", log_at(0), 32'h01);
        check("ovr_stat2_clear", log_at(1), 32'h00);
`else
        wait_log(3, "ovr_count");
        check("ovr_hdr", log_at(1), 32'h40);
        check("ovr_data", log_at(2), 32'h22);
        tick(8);
        check("ovr_no_extra", 32'(tx_log.size()), 32'd3);
        tx_log.delete();
        host_send(8'hC0);
        wait_log(1, "stat2_count");
        check("stat2_mask", log_at(0), 32'h01);
        tick(6);
        check("stat2_single", 32'(tx_log.size()), 32'd1);
`endif
        tx_log.delete();

        // Payload timeout: 0x55 then re-parses as a header (WRITE to absent ch 21).
        host_send(8'h41);
        repeat (Timeout) @(posedge clk);
        host_send(8'h55);
        tick(3);
        check("timeout_no_start", 32'(ch_total), 32'd2);
        host_send(8'h12);   // payload of the 0x55 header, dropped
        host_send(8'h41);
        host_send(8'h33);
        #1;
        check("post_timeout_start", 32'(ch_tx_start), 32'h2);
        check("post_timeout_data", 32'(ch_tx_data), 32'h33);
        tick(2);
        check("post_timeout_cnt", 32'(ch_total), 32'd3);
        ch_done(1);
        // Byte in the expiry cycle is still accepted.
        host_send(8'h41);
        repeat (Timeout - 1) @(posedge clk);
        host_send(8'hA5);
        #1;
        check("edge_timeout_start", 32'(ch_tx_start), 32'h2);
        check("edge_timeout_data", 32'(ch_tx_data), 32'hA5);
        ch_done(1);
        tick(2);

        // Reset while the data byte of a pair is in flight.
        stall = 1'b1;
        ch_send(4'b0001, 32'h0000_005A);
        wait_log(1, "rst_hdr_count");
        check("rst_hdr", log_at(0), 32'h40);
        stall = 1'b0;
        wait_log(2, "rst_data_count");
        stall = 1'b1;
        check("pre_rst_data", 32'(host_tx_data), 32'h5A);
        rst = 1'b1;
        #1;
        check("mid_rst_host_data", 32'(host_tx_data), 32'h0);
        check("mid_rst_host_start", 32'(host_tx_start), 32'h0);
        check("mid_rst_ch_data", 32'(ch_tx_data), 32'h0);
        check("mid_rst_ch_start", 32'(ch_tx_start), 32'h0);
        tick(2);
        rst = 1'b0;
        stall = 1'b0;
        tick(6);
        check("post_rst_no_host_start", 32'(tx_log.size()), 32'd2);
        check("post_rst_no_ch_start", 32'(ch_total), 32'd4);
        host_send(8'hC0);
`ifdef COMM_MUX_OVERRUN_EN
        wait_log(4, "post_rst_stat_count");
        check("post_rst_ovr", log_at(3), 32'h00);
`else
        wait_log(3, "post_rst_stat_count");
`endif
        check("post_rst_mask", log_at(2), 32'h00);

        check("host_protocol", 32'(proto_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
